// File: rtl/movegen_arbiter_pkg.sv
// Shared types and constants for the move-generator SDRAM arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package movegen_pkg;

    localparam int N_REQ_DEFAULT = 4;
    localparam int DATA_W        = 32;

    // Index width for a requester count; a single requester still needs one bit.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int REQ_IW = idx_width(N_REQ_DEFAULT);

    typedef logic [REQ_IW-1:0] req_idx_t;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        WAIT_RD = 2'd2
    } arb_state_t;

endpackage

// File: rtl/movegen_arbiter_if.sv
// Avalon-MM style bus bundle carrying NP parallel ports with one shared readdata.
// Latency: n/a (wires only).
// Backpressure: waitrequest per port, driven by the slave side.
// Ports: address/read/write/writedata flow master->slave;
//        waitrequest/readdata/readdatavalid flow slave->master.
interface movegen_arbiter_if #(
    parameter int NP = 1,
    parameter int AW = 32
);
    logic [NP-1:0][AW-1:0] address;
    logic [NP-1:0]         read;
    logic [NP-1:0]         write;
    logic [NP-1:0][31:0]   writedata;
    logic [NP-1:0]         waitrequest;
    logic [31:0]           readdata;
    logic [NP-1:0]         readdatavalid;

    modport master (
        output address, read, write, writedata,
        input  waitrequest, readdata, readdatavalid
    );

    modport slave (
        input  address, read, write, writedata,
        output waitrequest, readdata, readdatavalid
    );
endinterface

// File: rtl/movegen_arbiter_rr_picker.sv
// Round-robin winner selection: first active request at or after last_grant+1.
// Latency: purely combinational.
// Backpressure: none; win_vld is low when no request is active.
// Ports: req_vec (active requests), last_grant in; win_idx, win_vld out.
module rr_picker
    import movegen_pkg::*;
#(
    parameter  int N_REQ = N_REQ_DEFAULT,
    localparam int IW    = idx_width(N_REQ)
) (
    input  logic [N_REQ-1:0] req_vec,
    input  logic [IW-1:0]    last_grant,
    output logic [IW-1:0]    win_idx,
    output logic             win_vld
);

    always_comb begin
        int          k;
        logic [IW-1:0] k_idx;
        win_idx = '0;
        win_vld = 1'b0;
        k       = 0;
        k_idx   = '0;
        // Scan starting one past the previous winner so every port gets a turn.
        for (int i = 0; i < N_REQ; i++) begin
            k     = (int'(last_grant) + 1 + i) % N_REQ;
            k_idx = IW'(k);
            if (!win_vld && req_vec[k_idx]) begin
                win_vld = 1'b1;
                win_idx = k_idx;
            end
        end
    end

endmodule

// File: rtl/movegen_arbiter.sv
// Round-robin arbiter multiplexing N_REQ Avalon-MM requesters onto one SDRAM port.
// Latency: write 2 cycles (IDLE->ISSUE->IDLE); read 3 cycles plus SDRAM read latency.
// Backpressure: one transaction in flight; non-granted ports held by waitrequest=1,
//               granted port sees master waitrequest only while in ISSUE.
// Ports: clk, rst (async active-high); req (requester side, slave modport);
//        master (SDRAM side, master modport); grant_idx (debug, last/current winner).
module movegen_arbiter
    import movegen_pkg::*;
#(
    parameter  int N_REQ = N_REQ_DEFAULT,
    parameter  int AW    = 32,
    localparam int IW    = idx_width(N_REQ)
) (
    input  logic                clk,
    input  logic                rst,
    movegen_arbiter_if.slave    req,
    movegen_arbiter_if.master   master,
    output logic [IW-1:0]       grant_idx
);

    arb_state_t    state_q, state_d;
    logic [IW-1:0] grant_q, grant_d;
    logic [IW-1:0] last_q, last_d;

    logic [IW-1:0] pick_idx;
    logic          pick_vld;
    logic          cur_rd, cur_wr;
    logic [AW-1:0] cur_addr;
    logic [31:0]   cur_wdata;

    rr_picker #(.N_REQ(N_REQ)) u_picker (
        .req_vec    (req.read | req.write),
        .last_grant (last_q),
        .win_idx    (pick_idx),
        .win_vld    (pick_vld)
    );

    assign cur_rd    = req.read[grant_q];
    assign cur_wr    = req.write[grant_q];
    assign cur_addr  = req.address[grant_q];
    assign cur_wdata = req.writedata[grant_q];
    assign grant_idx = grant_q;

    // last_q resets to the top index so requester 0 wins the first scan.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            grant_q <= '0;
            last_q  <= IW'(N_REQ - 1);
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            last_q  <= last_d;
        end
    end

    always_comb begin
        state_d               = state_q;
        grant_d               = grant_q;
        last_d                = last_q;
        req.waitrequest       = '1;
        req.readdatavalid     = '0;
        req.readdata          = '0;
        master.address        = '0;
        master.read           = '0;
        master.write          = '0;
        master.writedata      = '0;

        case (state_q)
            IDLE: begin
                if (pick_vld) begin
                    grant_d = pick_idx;
                    state_d = ISSUE;
                end
            end

            ISSUE: begin
                master.address[0]            = cur_addr;
                master.writedata[0]          = cur_wdata;
                master.read[0]               = cur_rd;
                // Read wins when both strobes are set.
                master.write[0]              = cur_wr & ~cur_rd;
                req.waitrequest[grant_q]     = master.waitrequest[0];
                if (!cur_rd && !cur_wr) begin
                    // Requester withdrew; nothing was issued, so no completion.
                    state_d = IDLE;
                end else if (!master.waitrequest[0]) begin
                    if (cur_rd) begin
                        state_d = WAIT_RD;
                    end else begin
                        state_d = IDLE;
                        last_d  = grant_q;
                    end
                end
            end

            WAIT_RD: begin
                if (master.readdatavalid[0]) begin
                    req.readdatavalid[grant_q] = 1'b1;
                    req.readdata               = master.readdata;
                    last_d                     = grant_q;
                    state_d                    = IDLE;
                end
            end

            default: state_d = IDLE;
        endcase
    end

endmodule
